// File: rtl/alu_wide_seq_pkg.sv
// rtl/alu_wide_seq_pkg.sv - shared op and state encodings for the wide add/sub sequencer
// Contents: OP_ADD/OP_SUB op encodings, state_e FSM state type.
package alu_wide_seq_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/alu_wide_seq_if.sv
// rtl/alu_wide_seq_if.sv - issue-side request/response bundle of the wide add/sub sequencer
// master: issuer drives start/op/opa/opb, receives busy/done/result and wide flags.
// slave : sequencer receives the request and drives the response.
interface alu_wide_seq_if #(
   parameter int BUS   = 8,
   parameter int WORDS = 4
);
   localparam int W = BUS * WORDS;

   logic         start;
   logic         op;
   logic [W-1:0] opa;
   logic [W-1:0] opb;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         zero;
   logic         cout;
   logic         overflow;
   logic         negative;

   modport master (
      output start, op, opa, opb,
      input  busy, done, result, zero, cout, overflow, negative
   );

   modport slave (
      input  start, op, opa, opb,
      output busy, done, result, zero, cout, overflow, negative
   );

endinterface

// File: rtl/alu_wide_seq_wide_word_shreg.sv
// rtl/alu_wide_seq_wide_word_shreg.sv - W-bit register with parallel load and right shift by one slice
// Ports: clk, rst_n (async active-low), load_i/load_data_i parallel load (wins over shift),
//        shift_i/shift_in_i shift right by BUS with shift_in_i entering the top word, q_o register value.
module wide_word_shreg #(
   parameter int BUS   = 8,
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load_i,
   input  logic [BUS*WORDS-1:0]   load_data_i,
   input  logic                   shift_i,
   input  logic [BUS-1:0]         shift_in_i,
   output logic [BUS*WORDS-1:0]   q_o
);
   localparam int W = BUS * WORDS;

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = load_data_i;
      end else if (shift_i) begin
         // Concatenate then shift so WORDS=1 needs no empty part-select.
         q_d = W'({shift_in_i, q_q} >> BUS);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/alu_wide_seq.sv
// rtl/alu_wide_seq.sv - wide add/sub sequencer running one BUS-bit ALU slice WORDS times, LSW first
// Ports: clk, rst_n (async active-low); bus (slave modport of alu_wide_seq_if) request/response;
//        alu_a/alu_b/alu_cin/alu_c2 slice operands to the external combinational ALU;
//        alu_sout/alu_cout/alu_overflow slice results returned from that ALU.
module alu_wide_seq
   import alu_wide_seq_pkg::*;
#(
   parameter int BUS   = 8,
   parameter int WORDS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_wide_seq_if.slave    bus,
   output logic [BUS-1:0]   alu_a,
   output logic [BUS-1:0]   alu_b,
   output logic             alu_cin,
   output logic             alu_c2,
   input  logic [BUS-1:0]   alu_sout,
   input  logic             alu_cout,
   input  logic             alu_overflow
);
   localparam int W  = BUS * WORDS;
   localparam int CW = $clog2(WORDS) + 1;

   state_e          state_q;
   logic [CW-1:0]   cnt_q;
   logic            carry_q;
   logic            zacc_q;
   logic            busy_q;
   logic            done_q;
   logic [W-1:0]    result_q;
   logic            zero_q;
   logic            cout_q;
   logic            overflow_q;
   logic            negative_q;

   logic            accept;
   logic            running;
   logic            last_pass;
   logic            slice_zero;
   logic [W-1:0]    b_load;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;
   logic [W-1:0]    r_q;
   logic [W-1:0]    assembled;

   assign accept     = (state_q == ST_IDLE) && bus.start;
   assign running    = (state_q == ST_RUN);
   assign last_pass  = running && (cnt_q == CW'(WORDS - 1));
   assign slice_zero = (alu_sout == '0);

   // SUB is A + ~B + 1: invert B at load, the +1 comes from the initial carry.
   assign b_load = (bus.op == OP_SUB) ? ~bus.opb : bus.opb;

   wide_word_shreg #(.BUS(BUS), .WORDS(WORDS)) u_a_shreg (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (accept),
      .load_data_i (bus.opa),
      .shift_i     (running),
      .shift_in_i  ('0),
      .q_o         (a_q)
   );

   wide_word_shreg #(.BUS(BUS), .WORDS(WORDS)) u_b_shreg (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (accept),
      .load_data_i (b_load),
      .shift_i     (running),
      .shift_in_i  ('0),
      .q_o         (b_q)
   );

   // Slice sums enter at the top; after WORDS shifts the LSW has reached bit 0.
   wide_word_shreg #(.BUS(BUS), .WORDS(WORDS)) u_r_shreg (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (accept),
      .load_data_i ('0),
      .shift_i     (running),
      .shift_in_i  (alu_sout),
      .q_o         (r_q)
   );

   // Value the result register will hold after the final shift, taken one edge early.
   assign assembled = W'({alu_sout, r_q} >> BUS);

   assign alu_a   = running ? BUS'(a_q) : '0;
   assign alu_b   = running ? BUS'(b_q) : '0;
   assign alu_cin = running & carry_q;
   assign alu_c2  = running;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         carry_q    <= 1'b0;
         zacc_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b1;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
         negative_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
                  carry_q <= bus.op;
                  cnt_q   <= '0;
                  zacc_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               carry_q <= alu_cout;
               zacc_q  <= zacc_q & slice_zero;
               cnt_q   <= cnt_q + CW'(1);
               if (last_pass) begin
                  state_q    <= ST_DONE;
                  done_q     <= 1'b1;
                  result_q   <= assembled;
                  cout_q     <= alu_cout;
                  overflow_q <= alu_overflow;
                  negative_q <= alu_sout[BUS-1];
                  zero_q     <= zacc_q & slice_zero;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.zero     = zero_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = overflow_q;
   assign bus.negative = negative_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// tb/tb_alu_wide_seq.sv - scoreboard bench for alu_wide_seq with an attached slice ALU model
module tb_alu_wide_seq;
   import alu_wide_seq_pkg::*;

   localparam int BUS   = 8;
   localparam int WORDS = 4;
   localparam int W     = BUS * WORDS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [BUS-1:0] alu_a, alu_b, alu_sout;
   logic           alu_cin, alu_c2, alu_cout, alu_overflow;
   logic [BUS:0]   slice_sum;

   alu_wide_seq_if #(.BUS(BUS), .WORDS(WORDS)) bus ();

   alu_wide_seq #(.BUS(BUS), .WORDS(WORDS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_cin      (alu_cin),
      .alu_c2       (alu_c2),
      .alu_sout     (alu_sout),
      .alu_cout     (alu_cout),
      .alu_overflow (alu_overflow)
   );

   // Combinational slice ALU
   assign slice_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {{BUS{1'b0}}, alu_cin};
   assign alu_sout     = slice_sum[BUS-1:0];
   assign alu_cout     = slice_sum[BUS];
   assign alu_overflow = (alu_a[BUS-1] == alu_b[BUS-1]) && (alu_sout[BUS-1] != alu_a[BUS-1]);

   typedef struct {
      logic [W-1:0] res;
      logic         z;
      logic         c;
      logic         v;
      logic         n;
      int           a0;
      string        name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   cyc       = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Wide-operand reference: plain integer arithmetic on the whole W-bit values.
   function automatic exp_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [W:0] s;
      if (op == OP_ADD) begin
         s     = {1'b0, a} + {1'b0, b};
         e.res = s[W-1:0];
         e.c   = s[W];
         e.v   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end else begin
         e.res = a - b;
         e.c   = (a >= b);
         e.v   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      e.z  = (e.res == '0);
      e.n  = e.res[W-1];
      e.a0 = 0;
      e.name = "";
      return e;
   endfunction

   // Monitor: pops an expectation on every done and checks ALU-side outputs each cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.done) begin
            if (sb.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_done: got done=1, expected no pending operation (cycle %0d)", cyc);
            end else begin
               mon_e = sb.pop_front();
               chk({mon_e.name, "_result"},   bus.result,   mon_e.res);
               chk({mon_e.name, "_zero"},     bus.zero,     mon_e.z);
               chk({mon_e.name, "_cout"},     bus.cout,     mon_e.c);
               chk({mon_e.name, "_overflow"}, bus.overflow, mon_e.v);
               chk({mon_e.name, "_negative"}, bus.negative, mon_e.n);
               chk({mon_e.name, "_latency"},  cyc - mon_e.a0, WORDS + 1);
               chk({mon_e.name, "_busy_at_done"}, bus.busy, 1);
            end
         end
         chk("alu_c2_run_only", alu_c2, bus.busy && !bus.done);
         if (!(bus.busy && !bus.done))
            chk("alu_idle_zero", {alu_a, alu_b, alu_cin}, 0);
      end
   end

   // Call at a negedge while the DUT is idle; returns at the negedge of cycle 1.
   task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
      exp_t e;
      e      = model(op, a, b);
      e.a0   = cyc;
      e.name = name;
      sb.push_back(e);
      bus.start = 1'b1;
      bus.op    = op;
      bus.opa   = a;
      bus.opb   = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.op    = 1'($urandom);
      bus.opa   = $urandom;
      bus.opb   = $urandom;
   endtask

   // Returns at the negedge after done, the earliest cycle a new start is accepted.
   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!bus.done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.done) begin
         total_cnt++;
         $display("FAIL %s_timeout: got no done within 20 cycles, expected done", name);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion, expected summary");
      $fatal(1);
   end

   initial begin
      logic         rop;
      logic [W-1:0] ra, rb;

      bus.start = 1'b0;
      bus.op    = OP_ADD;
      bus.opa   = '0;
      bus.opb   = '0;
      repeat (3) @(negedge clk);

      chk("rst_busy",     bus.busy,     0);
      chk("rst_done",     bus.done,     0);
      chk("rst_result",   bus.result,   0);
      chk("rst_zero",     bus.zero,     1);
      chk("rst_flags",    {bus.cout, bus.overflow, bus.negative}, 0);
      chk("rst_alu",      {alu_a, alu_b, alu_cin, alu_c2}, 0);

      rst_n = 1'b1;
      @(negedge clk);

      issue(OP_ADD, 32'h0000_00FF, 32'h0000_0001, "t1_add_carry_chain"); wait_done("t1");
      issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, "t2_add_wrap");        wait_done("t2");
      issue(OP_SUB, 32'h8000_0000, 32'h0000_0001, "t3_sub_ovf");         wait_done("t3");
      issue(OP_SUB, 32'h0000_0005, 32'h0000_0005, "t4_sub_eq");          wait_done("t4a");
      issue(OP_SUB, 32'h0000_0000, 32'h0000_0001, "t4_sub_borrow");      wait_done("t4b");

      // Starts during RUN (cycle 2) and DONE (cycle 5) must be ignored.
      issue(OP_ADD, 32'h1234_5678, 32'h0FED_CBA9, "t5_first");
      for (int c = 2; c <= 5; c++) begin
         @(negedge clk);
         chk("t5_busy_hold", bus.busy, 1);
         if (c == 2 || c == 5) begin
            bus.start = 1'b1;
            bus.op    = OP_SUB;
            bus.opa   = $urandom;
            bus.opb   = $urandom;
         end else begin
            bus.start = 1'b0;
         end
      end
      @(negedge clk);
      chk("t5_idle_cycle6", bus.busy, 0);
      issue(OP_SUB, 32'hDEAD_BEEF, 32'h0BAD_F00D, "t5_second");
      wait_done("t5");

      // Reset in cycle 3 abandons the operation.
      issue(OP_ADD, 32'h0101_0101, 32'h0202_0202, "t6_abandoned");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy",   bus.busy,   0);
      chk("t6_rst_done",   bus.done,   0);
      chk("t6_rst_result", bus.result, 0);
      chk("t6_pending",    sb.size(),  1);
      if (sb.size() > 0) void'(sb.pop_back());
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_no_done_in_rst", bus.done, 0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_idle_after_rst", bus.busy, 0);
      issue(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, "t6_after_rst");
      wait_done("t6");

      for (int i = 0; i < 24; i++) begin
         rop = 1'($urandom);
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 3))
            0: rb = ra;
            1: rb = ~ra;
            2: ra = 32'h8000_0000;
            default: ;
         endcase
         issue(rop, ra, rb, $sformatf("rnd%0d", i));
         wait_done("rnd");
      end

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
